prog_load_ctrl: RTL

Sequencing controller for the UART program loader. It consumes the received byte stream, frames it into 32-bit instruction words and drives the instruction memory's programmer write port (write enable, word address, data). It also drives the done flag that switches that memory back to CPU fetch. It sits between the UART receiver and the program ROM, and also holds the CPU while an image is being written.

---
 rtl/prog_load_pkg.sv | 20 ++
 rtl/prog_load_timeout.sv | 45 ++++
 rtl/prog_load_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/prog_load_pkg.sv
// prog_load_pkg: shared definitions for the UART program loader controller.
//   state_t          loader FSM states
//   LEN_W            width of the little-endian word-count field in the frame
//   TIMEOUT_CYC_DEF  default inter-byte idle limit (100 ms at 10 MHz)
package prog_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned LEN_W           = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 1000000;

endpackage

// File: rtl/prog_load_timeout.sv
// prog_load_timeout: idle-cycle counter for the program loader.
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   clr_i           clear the count (takes priority over en_i)
//   en_i            count one idle cycle
//   tc_o            the count reaches TIMEOUT_CYC on this clock edge
module prog_load_timeout
  import prog_load_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_q;
    if (clr_i) begin
      cnt_nxt = '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_nxt = cnt_q + CW'(1);
    end
  end

  // Flagged from the incoming count so a registered consumer switches in the
  // same cycle the count becomes TIMEOUT_CYC.
  assign tc_o = en_i && !clr_i && (cnt_nxt == TC);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: frames the UART byte stream (LEN_LO, LEN_HI, N x 4-byte
// words LSB first) into 32-bit writes on the program memory's programmer port
// and holds the CPU while a load is in progress.
//   clk_i, rst_n_i   loader clock, asynchronous active-low reset
//   start_i          pulse: begin a new load (ignored while loading)
//   rx_valid_i       strobe: rx_byte_i is valid (ignored when not loading)
//   rx_byte_i        received byte
//   upg_wen_o        one-cycle memory write enable
//   upg_adr_o        memory word address (held until the next write)
//   upg_dat_o        memory write data (held until the next write)
//   upg_done_o       1 = memory belongs to the CPU
//   cpu_hold_o       stall CPU fetch while loading or after a failure
//   err_o            the load failed (length, timeout or checksum)
// Optional feature: define PRG_LOAD_CHKSUM_EN to require a trailing XOR
// checksum byte over all data bytes (CHK state).
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              cpu_hold_o,
  output logic              err_o
);

  typedef logic [ADDR_W:0] widx_t;

  localparam logic [63:0] MAX_N = 64'd1 << ADDR_W;

  state_t           state_q, state_nxt;
  logic [7:0]       len_lo_q;
  widx_t            n_words_q;
  widx_t            word_idx_q;
  logic [1:0]       byte_idx_q;
  logic [23:0]      word_q;
`ifdef PRG_LOAD_CHKSUM_EN
  logic [7:0]       chk_q;
`endif

  logic             loading;
  logic             start_acc;
  logic             data_cap;
  logic             word_end;
  logic             last_word;
  logic             to_tc;
  logic [LEN_W-1:0] len_in;

  assign loading   = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK};
  assign start_acc = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign len_in    = {rx_byte_i, len_lo_q};
  // Once every word is captured, further strobes in DATA are not data bytes.
  assign data_cap  = (state_q == ST_DATA) && rx_valid_i && (word_idx_q != n_words_q);
  assign word_end  = data_cap && (byte_idx_q == 2'd3);
  assign last_word = (word_idx_q == (n_words_q - widx_t'(1)));

  prog_load_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (!loading || rx_valid_i),
    .en_i   (loading),
    .tc_o   (to_tc)
  );

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (rx_valid_i) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (rx_valid_i) begin
          if (len_in == '0)                state_nxt = ST_DONE;
          else if (64'(len_in) > MAX_N)    state_nxt = ST_ERR;
          else                             state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
`ifdef PRG_LOAD_CHKSUM_EN
        if (word_end && last_word) state_nxt = ST_CHK;
`else
        // Final write pulse is on the port now and the index has already
        // moved past it, so done follows the pulse by one cycle.
        if (upg_wen_o && (word_idx_q == n_words_q)) state_nxt = ST_DONE;
`endif
      end
`ifdef PRG_LOAD_CHKSUM_EN
      ST_CHK: begin
        if (rx_valid_i) state_nxt = (rx_byte_i == chk_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
    if (loading && to_tc) state_nxt = ST_ERR;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      upg_done_o <= 1'b1;
      cpu_hold_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      upg_done_o <= (state_nxt inside {ST_IDLE, ST_DONE});
      cpu_hold_o <= !(state_nxt inside {ST_IDLE, ST_DONE});
      err_o      <= (state_nxt == ST_ERR);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len_lo_q   <= '0;
      n_words_q  <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
`ifdef PRG_LOAD_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      upg_wen_o <= 1'b0;
      if (start_acc) begin
        word_idx_q <= '0;
        byte_idx_q <= '0;
`ifdef PRG_LOAD_CHKSUM_EN
        chk_q      <= '0;
`endif
      end
      if ((state_q == ST_LEN_LO) && rx_valid_i) len_lo_q  <= rx_byte_i;
      // Oversize lengths are truncated here but never used: they go to ERR.
      if ((state_q == ST_LEN_HI) && rx_valid_i) n_words_q <= widx_t'(len_in);
      if (data_cap) begin
        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef PRG_LOAD_CHKSUM_EN
        chk_q      <= chk_q ^ rx_byte_i;
`endif
        unique case (byte_idx_q)
          2'd0: word_q[7:0]   <= rx_byte_i;
          2'd1: word_q[15:8]  <= rx_byte_i;
          2'd2: word_q[23:16] <= rx_byte_i;
          2'd3: begin
            upg_wen_o  <= 1'b1;
            upg_adr_o  <= word_idx_q[ADDR_W-1:0];
            upg_dat_o  <= {rx_byte_i, word_q};
            word_idx_q <= word_idx_q + widx_t'(1);
          end
        endcase
      end
    end
  end

endmodule
